// File: rtl/regfile_pkg.sv
// Shared defaults and helpers for the multi-port register file and its scoreboard.
// Latency: n/a (constants and a constant function only).
// Backpressure: n/a.
package regfile_pkg;

  localparam int DEF_WIDTH  = 16;
  localparam int DEF_DEPTH  = 8;
  localparam int DEF_NUM_RD = 2;

  // Register 0 is hardwired to zero and can never be marked busy.
  localparam int ZERO_REG = 0;

  // Register address width for a given number of registers.
  function automatic int calc_aw(input int depth);
    return $clog2(depth);
  endfunction

endpackage

// File: rtl/regfile_scoreboard.sv
// Busy-bit scoreboard: marks destination registers pending at issue, clears them on write-back.
// Latency: busy bits and count update on the rising edge; outputs are straight from registers.
// Backpressure: none; a set and a clear to the same register in one cycle resolve to busy.
//
// Ports:
//   clk, reset              clock, asynchronous active-high reset
//   i_set / i_set_addr      mark a register pending
//   i_clr0 / i_clr0_addr    write-back on write port 0 (clears busy)
//   i_clr1 / i_clr1_addr    write-back on write port 1 (clears busy)
//   o_busy_vec              current busy bits (bit 0 always 0)
//   o_busy_count            number of busy registers, kept as a running count
module regfile_scoreboard
  import regfile_pkg::*;
#(
  parameter int  DEPTH = DEF_DEPTH,
  localparam int AW    = calc_aw(DEPTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_set,
  input  logic [AW-1:0]    i_set_addr,
  input  logic             i_clr0,
  input  logic [AW-1:0]    i_clr0_addr,
  input  logic             i_clr1,
  input  logic [AW-1:0]    i_clr1_addr,
  output logic [DEPTH-1:0] o_busy_vec,
  output logic [AW:0]      o_busy_count
);

  localparam logic [AW-1:0] ZADDR = AW'(ZERO_REG);

  logic [DEPTH-1:0] r_busy;
  logic [AW:0]      r_count;

  logic             w_set_ok, w_clr0_ok, w_clr1_ok;
  logic             w_inc, w_dec0, w_dec1;
  logic [DEPTH-1:0] w_busy_nxt;

  assign w_set_ok  = i_set  && (i_set_addr  != ZADDR);
  assign w_clr0_ok = i_clr0 && (i_clr0_addr != ZADDR);
  assign w_clr1_ok = i_clr1 && (i_clr1_addr != ZADDR);

  // Count only real bit transitions: a set on an already-busy register adds
  // nothing, a clear overridden by a same-address set removes nothing, and
  // both write ports clearing the same register remove it once.
  assign w_inc  = w_set_ok && !r_busy[i_set_addr];
  assign w_dec0 = w_clr0_ok && r_busy[i_clr0_addr] &&
                  !(w_set_ok && (i_set_addr == i_clr0_addr));
  assign w_dec1 = w_clr1_ok && r_busy[i_clr1_addr] &&
                  !(w_set_ok && (i_set_addr == i_clr1_addr)) &&
                  !(w_clr0_ok && (i_clr0_addr == i_clr1_addr));

  always_comb begin
    w_busy_nxt = r_busy;
    if (w_clr0_ok) w_busy_nxt[i_clr0_addr] = 1'b0;
    if (w_clr1_ok) w_busy_nxt[i_clr1_addr] = 1'b0;
    // A new producer supersedes the one writing back this cycle.
    if (w_set_ok)  w_busy_nxt[i_set_addr]  = 1'b1;
    w_busy_nxt[ZERO_REG] = 1'b0;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_busy  <= '0;
      r_count <= '0;
    end else begin
      r_busy  <= w_busy_nxt;
      r_count <= r_count + (AW+1)'(w_inc) - (AW+1)'(w_dec0) - (AW+1)'(w_dec1);
    end
  end

  assign o_busy_vec   = r_busy;
  assign o_busy_count = r_count;

endmodule

// File: rtl/regfile_mp_sb.sv
// Multi-port register file (NUM_RD reads, 2 writes) with write-first bypass, zero register and busy scoreboard.
// Latency: reads combinational (READ_LATENCY=0) or registered one cycle (READ_LATENCY=1); rd_busy always combinational.
// Backpressure: none; every write and set is accepted the cycle it is presented, port 1 wins write conflicts.
//
// Ports:
//   clk, reset                  clock, asynchronous active-high reset
//   rd_addr / rd_data / rd_busy read ports, port k at slice k
//   we0/wa0/wd0, we1/wa1/wd1    write ports (port 1 has priority)
//   sb_set / sb_addr            mark destination register pending
//   busy_vec / busy_count       scoreboard state
module regfile_mp_sb
  import regfile_pkg::*;
#(
  parameter int  WIDTH        = DEF_WIDTH,
  parameter int  DEPTH        = DEF_DEPTH,
  parameter int  NUM_RD       = DEF_NUM_RD,
  parameter int  READ_LATENCY = 0,
  localparam int AW           = calc_aw(DEPTH)
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [NUM_RD*AW-1:0]    rd_addr,
  output logic [NUM_RD*WIDTH-1:0] rd_data,
  output logic [NUM_RD-1:0]       rd_busy,
  input  logic                    we0,
  input  logic [AW-1:0]           wa0,
  input  logic [WIDTH-1:0]        wd0,
  input  logic                    we1,
  input  logic [AW-1:0]           wa1,
  input  logic [WIDTH-1:0]        wd1,
  input  logic                    sb_set,
  input  logic [AW-1:0]           sb_addr,
  output logic [DEPTH-1:0]        busy_vec,
  output logic [AW:0]             busy_count
);

  localparam logic [AW-1:0] ZADDR = AW'(ZERO_REG);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic             w_wr0, w_wr1;

  assign w_wr0 = we0 && (wa0 != ZADDR);
  assign w_wr1 = we1 && (wa1 != ZADDR);

  // Port 1 is applied last so it wins a same-address conflict.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
    end else begin
      if (w_wr0) r_mem[wa0] <= wd0;
      if (w_wr1) r_mem[wa1] <= wd1;
    end
  end

  for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
    logic [AW-1:0]    w_addr;
    logic [WIDTH-1:0] w_eff;

    assign w_addr = rd_addr[k*AW +: AW];

    // Write-first bypass: a read sees the write landing at the coming edge.
    always_comb begin
      w_eff = r_mem[w_addr];
      if (w_wr0 && (wa0 == w_addr)) w_eff = wd0;
      if (w_wr1 && (wa1 == w_addr)) w_eff = wd1;
      if (w_addr == ZADDR)          w_eff = '0;
    end

    // Busy reflects state before the edge; a same-cycle clear is not bypassed.
    assign rd_busy[k] = busy_vec[w_addr];

    if (READ_LATENCY == 0) begin : g_comb
      assign rd_data[k*WIDTH +: WIDTH] = w_eff;
    end else begin : g_reg
      logic [WIDTH-1:0] r_rd;
      always_ff @(posedge clk or posedge reset) begin
        if (reset) r_rd <= '0;
        else       r_rd <= w_eff;
      end
      assign rd_data[k*WIDTH +: WIDTH] = r_rd;
    end
  end

  regfile_scoreboard #(
    .DEPTH(DEPTH)
  ) u_sb (
    .clk         (clk),
    .reset       (reset),
    .i_set       (sb_set),
    .i_set_addr  (sb_addr),
    .i_clr0      (we0),
    .i_clr0_addr (wa0),
    .i_clr1      (we1),
    .i_clr1_addr (wa1),
    .o_busy_vec  (busy_vec),
    .o_busy_count(busy_count)
  );

endmodule

// File: doc/regfile_mp_sb.md
Name: regfile_mp_sb

Overview:
Parametrised multi-port register file for the pipelined datapath, with a configurable number of read ports and two write ports. It adds same-cycle write-to-read bypass, a hardwired-zero register 0 and an asynchronous reset to zero. It also carries a busy-bit scoreboard that the decode stage uses to detect RAW hazards on pending destination registers. It replaces the fixed 8x16, 2-read/1-write, negedge-write register file.

Parameters:
WIDTH, 16, data word width in bits
DEPTH, 8, number of registers; power of two, >= 2
AW, $clog2(DEPTH), register address width (derived, not overridden)
NUM_RD, 2, number of read ports, 1..4
READ_LATENCY, 0, 0 = combinational read; 1 = registered read

Ports:
clk  in  1  clock; all state updates on the rising edge
reset  in  1  asynchronous, active-high reset
rd_addr  in  NUM_RD*AW  read addresses; port k uses bits [k*AW +: AW]
rd_data  out  NUM_RD*WIDTH  read data; port k uses bits [k*WIDTH +: WIDTH]
rd_busy  out  NUM_RD  scoreboard busy bit for each rd_addr (always combinational)
we0  in  1  write enable, port 0
wa0  in  AW  write address, port 0
wd0  in  WIDTH  write data, port 0
we1  in  1  write enable, port 1 (higher priority)
wa1  in  AW  write address, port 1
wd1  in  WIDTH  write data, port 1
sb_set  in  1  mark a destination register pending (issue)
sb_addr  in  AW  register to mark pending
busy_vec  out  DEPTH  current busy bits
busy_count  out  AW+1  number of busy registers

Behaviour:
- Reset (asynchronous, active-high):
  - all registers = 0; busy_vec = 0; busy_count = 0
  - READ_LATENCY=1: rd_data = 0
  - reset mid-write discards the write; reset overrides everything
- Register 0:
  - always reads 0; writes to address 0 are ignored
  - sb_set to address 0 is ignored; busy_vec[0] is always 0
- Write:
  - on a rising edge, each enabled port with address != 0 updates its register
  - we0 and we1 to the same address: port 1 wins
- Read, READ_LATENCY=0:
  - rd_data[k] = effective value of rd_addr[k], same cycle
  - effective value = wd1 if we1 && wa1==addr && addr!=0; else wd0 if we0 && wa0==addr && addr!=0; else array content
  - i.e. write-first bypass, so a read sees the write of the same cycle (same as the old negedge-write timing)
- Read, READ_LATENCY=1:
  - rd_data[k] is registered at the rising edge from the effective value above
  - data is valid one cycle after the address; the bypass still applies to the write occurring at that edge
- Scoreboard:
  - a write on port p (we_p, wa_p != 0) clears busy[wa_p]
  - sb_set sets busy[sb_addr]
  - sb_set and a write to the same address in the same cycle: set wins (a new producer supersedes the old)
  - sb_set on an already-busy register: stays busy; no error flag
  - busy_count always equals popcount(busy_vec), maintained incrementally as a registered counter (+1/-1/+-2 per cycle per net set/clear), not recomputed
  - busy_count saturates neither way; the scoreboard invariants guarantee 0..DEPTH-1
- rd_busy[k] = busy_vec[rd_addr[k]]
  - rd_busy is combinational in both latency modes
  - it reflects state before the current edge (no bypass of the same-cycle clear)

Decomposition:
- Package regfile_pkg: defaults for WIDTH/DEPTH/NUM_RD, a function to compute AW, and localparam ZERO_REG = 0.
- One sub-module, regfile_scoreboard: holds the busy bits, set/clear priority and busy_count; parametrised on DEPTH.
- The storage array, bypass muxes and read pipeline stay in the top module.

Test Plan:
1. Reset asserted asynchronously mid-cycle after writing R3=0x1234 -> R3 reads 0x0000 immediately; busy_count=0; rd_data=0 when READ_LATENCY=1.
2. we0 to R2 with 0xBBBB while rd_addr[0]=2, latency 0 -> same cycle rd_data[0]=0xBBBB; next cycle still 0xBBBB. Latency 1 -> rd_data[0]=0xBBBB one cycle after the edge.
3. we0 (R5, 0x1111) and we1 (R5, 0x2222) in the same cycle -> R5=0x2222; write to R0 of 0xFFFF -> R0 reads 0x0000.
4. sb_set R4, then R6 -> busy_vec=0x50, busy_count=2, rd_busy for R4 = 1; we1 to R4 -> busy_vec=0x40, busy_count=1.
5. sb_set R6 and we0 to R6 in the same cycle while R6 is busy -> R6 data updated, busy[6] stays 1, busy_count unchanged.
6. NUM_RD=4, DEPTH=16, WIDTH=32: sb_set sweeps all 15 registers, then all are written back (two per cycle with distinct addresses) -> busy_count peaks at 15 and returns to 0; random reads match a reference model every cycle.
